// File: rtl/trig_seq_gen.sv
// -----------------------------------------------------------------------------
// trig_seq_gen
// Directed stimulus sequencer feeding 128-bit plaintext words into the AES core
// over a valid/ready handshake. It plays a fixed 4-word sequence (W0..W3)
// rep_cfg times, with gap_cfg idle cycles after every accepted word except the
// last. It is the producer of the sequence watched by the state-sequence
// trigger monitor.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset
//   start     : one-cycle start request, sampled only in IDLE
//   abort     : synchronous abort, priority just below rst
//   gap_cfg   : idle cycles between accepted words (latched at start)
//   rep_cfg   : number of full 4-word sequences (latched at start)
//   pt_valid  : plaintext word valid
//   pt_data   : plaintext word (0 whenever no word is presented)
//   pt_ready  : core accepts the word when pt_valid & pt_ready at an edge
//   word_idx  : index 0..3 of the word currently presented
//   busy      : high in SEND and GAP
//   done      : one-cycle pulse after the last word of the last repeat
//   aborted   : one-cycle pulse when abort takes effect
// -----------------------------------------------------------------------------
module trig_seq_gen #(
   parameter int           GAP_W = 8,
   parameter int           REP_W = 4,
   parameter logic [127:0] W0    = 128'h3243f6a8_885a308d_313198a2_e0370734,
   parameter logic [127:0] W1    = 128'h00112233_44556677_8899aabb_ccddeeff,
   parameter logic [127:0] W2    = 128'h0,
   parameter logic [127:0] W3    = 128'h1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [GAP_W-1:0] gap_cfg,
   input  logic [REP_W-1:0] rep_cfg,
   output logic             pt_valid,
   output logic [127:0]     pt_data,
   input  logic             pt_ready,
   output logic [1:0]       word_idx,
   output logic             busy,
   output logic             done,
   output logic             aborted
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};
   localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   logic [GAP_W-1:0] gap_r;      // latched gap configuration
   logic [GAP_W-1:0] gap_cnt_r;  // cycles left in the current gap
   logic [REP_W-1:0] rep_cnt_r;  // sequences still to be completed
   logic             hs_s;

   // Sequence word for a given index.
   function automatic logic [127:0] word_at(input logic [1:0] idx);
      logic [127:0] w;
      case (idx)
         2'd0:    w = W0;
         2'd1:    w = W1;
         2'd2:    w = W2;
         2'd3:    w = W3;
         default: w = 128'h0;
      endcase
      return w;
   endfunction

   // Handshake: valid is only ever high in SEND.
   assign hs_s = pt_valid & pt_ready;

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         gap_r     <= '0;
         gap_cnt_r <= '0;
         rep_cnt_r <= '0;
         pt_valid  <= 1'b0;
         pt_data   <= 128'h0;
         word_idx  <= 2'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b0;
      end else if (abort && (state_r != ST_IDLE)) begin
         state_r   <= ST_IDLE;
         gap_cnt_r <= '0;
         rep_cnt_r <= '0;
         pt_valid  <= 1'b0;
         pt_data   <= 128'h0;
         word_idx  <= 2'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         aborted   <= 1'b1;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // abort in IDLE suppresses start but raises no pulse
               if (start && !abort) begin
                  gap_r <= gap_cfg;
                  if (rep_cfg != '0) begin
                     state_r   <= ST_SEND;
                     rep_cnt_r <= rep_cfg;
                     pt_valid  <= 1'b1;
                     pt_data   <= W0;
                     word_idx  <= 2'd0;
                     busy      <= 1'b1;
                  end else begin
                     state_r <= ST_FIN;
                     done    <= 1'b1;
                  end
               end
            end
            ST_SEND: begin
               if (hs_s) begin
                  if (word_idx == 2'd3) begin
                     word_idx  <= 2'd0;
                     rep_cnt_r <= rep_cnt_r - REP_ONE;
                     if (rep_cnt_r == REP_ONE) begin
                        state_r  <= ST_FIN;
                        pt_valid <= 1'b0;
                        pt_data  <= 128'h0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                     end else if (gap_r != '0) begin
                        state_r   <= ST_GAP;
                        gap_cnt_r <= gap_r;
                        pt_valid  <= 1'b0;
                        pt_data   <= 128'h0;
                     end else begin
                        pt_data <= W0;
                     end
                  end else begin
                     word_idx <= word_idx + 2'd1;
                     if (gap_r != '0) begin
                        state_r   <= ST_GAP;
                        gap_cnt_r <= gap_r;
                        pt_valid  <= 1'b0;
                        pt_data   <= 128'h0;
                     end else begin
                        pt_data <= word_at(word_idx + 2'd1);
                     end
                  end
               end
            end
            ST_GAP: begin
               // leaving when the count reads 1 gives exactly gap_r valid-low cycles
               if (gap_cnt_r == GAP_ONE) begin
                  state_r   <= ST_SEND;
                  gap_cnt_r <= '0;
                  pt_valid  <= 1'b1;
                  pt_data   <= word_at(word_idx);
               end else begin
                  gap_cnt_r <= gap_cnt_r - GAP_ONE;
               end
            end
            ST_FIN: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r  <= ST_IDLE;
               pt_valid <= 1'b0;
               pt_data  <= 128'h0;
               word_idx <= 2'd0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
